timer_sched: RTL
================

# timer_sched

Round-robin scheduler that shares one programmable one-shot delay counter among `N_REQ` requesters. Each requester raises `req` with its own delay value. The block grants the counter to one requester at a time and runs it for `delay+1` cycles. It then pulses `done` to that requester and re-arbitrates. It sits between the requesting control FSMs and the shared count-to-terminal timer resource.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `CNT_W`, default 3: counter/delay width; max delay `2**CNT_W-1`.
- `IDX_W`, default `$clog2(N_REQ)`: owner index width, derived, not overridden.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input `N_REQ`: level request per requester; held until `done` or intentionally dropped (abort).
- `delay` input `N_REQ*CNT_W`: requester i's delay at bits `[i*CNT_W +: CNT_W]`; sampled only at grant.
- `gnt` output `N_REQ`: one-hot/zero, registered; high while the owner's count runs.
- `done` output `N_REQ`: one-hot/zero single-cycle completion pulse, registered.
- `owner` output `IDX_W`: index of current/last grantee.
- `busy` output 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `req` ≠ 0, pick the winner by round-robin search starting at `ptr` and wrapping.
  - Then `owner<=win`, `dly<=delay[win]`, `cnt<=0`, `gnt<=onehot(win)`, `ptr<=(win+1) mod N_REQ`, go to RUN.
  - Else stay in IDLE.
- RUN:
  - If `req[owner]`=0: abort. `gnt<=0`, no `done`, go to IDLE.
  - Else if `cnt==dly`: `gnt<=0`, `done<=onehot(owner)`, go to DONE.
  - Else `cnt<=cnt+1`.
- DONE: `done<=0`, go to IDLE; `req` ignored this state.
- `cnt` never exceeds `dly`, so there is no wrap; comparison is `CNT_W`-bit unsigned.
- `delay` changes after grant are ignored. The latched `dly` governs the run.
- A requester still holding `req` after its `done` re-enters arbitration. `ptr` already points past it, so the other requesters win first.
- `ptr` wraps `N_REQ-1 → 0`. A non-power-of-2 `N_REQ` must never select an index ≥ `N_REQ`.
- Reset values:
  - state=IDLE, `cnt`=0, `dly`=0, `ptr`=0.
  - `gnt`=0, `done`=0, `owner`=0, `busy`=0.
- Reset mid-run: all registers return to reset values at that edge. No `done` is issued for the interrupted run.

## Timing
- Request seen in IDLE at edge T: `gnt` high from T+1.
- Delay d: `gnt` high for exactly d+1 cycles. `done` is high for 1 cycle, immediately after `gnt` falls.
- The next grant appears 2 cycles after `done` rises (DONE cycle, then IDLE arbitration cycle).
- Delay 0: `gnt` 1 cycle, then `done`.
- Abort: `gnt` falls the cycle after `req[owner]` is sampled low. Next arbitration happens the cycle after that.
- `gnt` and `done` are never both high. Each is at most one bit hot.

## Structure
- `timer_sched_pkg`: state enum (IDLE/RUN/DONE), default `N_REQ`/`CNT_W` localparams.
- Sub-module `rr_arbiter`:
  - Combinational round-robin pick: `req`, `ptr` in; `win` index and `any` flag out.
  - `ptr` register stays in `timer_sched`.
- Top holds the FSM, `cnt`/`dly`/`owner` registers and output registers.

## Test plan
- **Single request, long delay.** `req=4'b0001`, delay0=7, held → `gnt=0001` for 8 cycles starting T+1, `done=0001` one cycle at T+9, `busy` low at T+10.
- **Simultaneous requests.** `req=4'b0101` at once, delays 2 and 1 → grant order requester 0 (3 cycles), `done[0]`, then requester 2 (2 cycles), `done[2]`.
- **Fairness.** All four requesting continuously, delay 0 each → grant sequence 0,1,2,3,0,1, each `gnt` 1 cycle, with `done` 1 cycle, IDLE 1 cycle.
- **Delay capture at grant.** Grant requester 1 with delay=5, then change `delay[1]` to 1 mid-run → run still lasts 6 cycles.
- **Abort.** Requester 3 (delay 6) drops `req` at RUN cycle 2 → `gnt` falls next cycle, no `done[3]`, and a pending `req[0]` is granted 2 cycles later.
- **Reset mid-run.** Assert `rst` during RUN → next cycle `gnt`, `done`, `busy`, `owner` all 0. After `rst` is released with `req=0010`, requester 1 is granted (`ptr` back at 0).

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared FSM state type and default sizing for the timer scheduler
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i and wrapping at N_REQ
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan offsets from farthest to nearest so the closest requester to ptr_i is the last write
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        sum   = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            idx = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ)) : IDX_W'(sum);
            if (req_i[idx]) win_o = idx;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one one-shot delay counter among N_REQ requesters
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CNT_W-1:0] delay_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [IDX_W-1:0]       owner_o,
    output logic                   busy_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, dly_q;
    logic [IDX_W-1:0] owner_q, ptr_q, ptr_d, win;
    logic [N_REQ-1:0] gnt_q, done_q;
    logic             any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any)
    );

    assign ptr_d = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;

    // done_q defaults low each cycle so it is a single-cycle pulse out of RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: if (any) begin
                    owner_q <= win;
                    dly_q   <= delay_i[win*CNT_W +: CNT_W];
                    cnt_q   <= '0;
                    gnt_q   <= N_REQ'(1) << win;
                    ptr_q   <= ptr_d;
                    state_q <= RUN;
                end
                RUN: if (!req_i[owner_q]) begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end else if (cnt_q == dly_q) begin
                    gnt_q   <= '0;
                    done_q  <= N_REQ'(1) << owner_q;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q != IDLE);

endmodule
